// File: rtl/jogador_automatico.sv
// jogador_automatico: captures LED patterns shown by the game and replays them as timed key presses.
// Rev 1.0
`default_nettype none

module jogador_automatico #(
   parameter int unsigned T_PRESS = 4,
   parameter int unsigned T_GAP   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] leds,
   input  logic       limpa,
   input  logic       jogar,
   output logic [3:0] chaves,
   output logic       ocupado,
   output logic       pronto,
   output logic       overflow,
   output logic [1:0] db_estado,
   output logic [4:0] db_quantidade
);

   typedef enum logic [1:0] {
      CAPTURA   = 2'd0,
      PRESSIONA = 2'd1,
      SOLTA     = 2'd2,
      FIM       = 2'd3
   } state_t;

   localparam logic [7:0] C_PRESS_RELOAD = 8'(T_PRESS - 1);
   localparam logic [7:0] C_GAP_RELOAD   = 8'(T_GAP - 1);
   localparam logic [4:0] C_DEPTH        = 5'd16;

   state_t     state_q,     state_d;
   logic [4:0] wr_ptr_q,    wr_ptr_d;
   logic [4:0] rd_ptr_q,    rd_ptr_d;
   logic [7:0] timer_q,     timer_d;
   logic [3:0] leds_prev_q, leds_prev_d;
   logic [3:0] chaves_q,    chaves_d;
   logic       ocupado_q,   ocupado_d;
   logic       pronto_q,    pronto_d;
   logic       overflow_q,  overflow_d;

   logic [3:0] buf_mem [16];
   logic       buf_we;
   logic       capture;
   logic [4:0] rd_next;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      timer_d     = timer_q;
      chaves_d    = chaves_q;
      pronto_d    = 1'b0;
      overflow_d  = overflow_q;
      leds_prev_d = leds;
      buf_we      = 1'b0;
      rd_next     = rd_ptr_q + 5'd1;
      capture     = (leds != 4'd0) && (leds_prev_q == 4'd0);

      if (limpa) begin
         state_d    = CAPTURA;
         wr_ptr_d   = 5'd0;
         rd_ptr_d   = 5'd0;
         timer_d    = 8'd0;
         chaves_d   = 4'd0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            CAPTURA: begin
               // jogar beats a simultaneous capture event
               if (jogar) begin
                  rd_ptr_d = 5'd0;
                  if (wr_ptr_q != 5'd0) begin
                     state_d  = PRESSIONA;
                     chaves_d = buf_mem[0];
                     timer_d  = C_PRESS_RELOAD;
                  end else begin
                     state_d  = FIM;
                     chaves_d = 4'd0;
                     pronto_d = 1'b1;
                     timer_d  = 8'd0;
                  end
               end else if (capture) begin
                  if (wr_ptr_q < C_DEPTH) begin
                     buf_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + 5'd1;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end
            PRESSIONA: begin
               if (timer_q == 8'd0) begin
                  state_d  = SOLTA;
                  chaves_d = 4'd0;
                  timer_d  = C_GAP_RELOAD;
               end else begin
                  timer_d = timer_q - 8'd1;
               end
            end
            SOLTA: begin
               if (timer_q == 8'd0) begin
                  rd_ptr_d = rd_next;
                  if (rd_next < wr_ptr_q) begin
                     state_d  = PRESSIONA;
                     chaves_d = buf_mem[rd_next[3:0]];
                     timer_d  = C_PRESS_RELOAD;
                  end else begin
                     state_d  = FIM;
                     chaves_d = 4'd0;
                     pronto_d = 1'b1;
                     timer_d  = 8'd0;
                  end
               end else begin
                  timer_d = timer_q - 8'd1;
               end
            end
            FIM: begin
               // The game shows the whole sequence again next round
               state_d  = CAPTURA;
               wr_ptr_d = 5'd0;
               rd_ptr_d = 5'd0;
               timer_d  = 8'd0;
               chaves_d = 4'd0;
            end
            default: begin
               state_d  = CAPTURA;
               chaves_d = 4'd0;
               timer_d  = 8'd0;
            end
         endcase
      end

      ocupado_d = (state_d == PRESSIONA) || (state_d == SOLTA);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= CAPTURA;
         wr_ptr_q    <= 5'd0;
         rd_ptr_q    <= 5'd0;
         timer_q     <= 8'd0;
         leds_prev_q <= 4'd0;
         chaves_q    <= 4'd0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         timer_q     <= timer_d;
         leds_prev_q <= leds_prev_d;
         chaves_q    <= chaves_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage needs no reset: entries at or above wr_ptr are never read
   always_ff @(posedge clock) begin
      if (buf_we) begin
         buf_mem[wr_ptr_q[3:0]] <= leds;
      end
   end

   assign chaves        = chaves_q;
   assign ocupado       = ocupado_q;
   assign pronto        = pronto_q;
   assign overflow      = overflow_q;
   assign db_estado     = state_q;
   assign db_quantidade = wr_ptr_q;

endmodule

`default_nettype wire
